fir_tap_buffer: RTL

//  Coefficient store for the FIR HWPE; the stage directly after the H source streamer.

---
 rtl/fir_tap_buffer_pkg.sv | 28 ++
 rtl/fir_tap_buffer.sv | 102 ++++++++++
 2 files changed

// File: rtl/fir_tap_buffer_pkg.sv
// Shared types for the FIR coefficient buffer: FSM state, status flags and
// control bundle, plus the word-count helper used to size the loader.
package fir_tap_buffer_pkg;

  localparam int NB_TAPS_DEF    = 50;
  localparam int TAP_WIDTH_DEF  = 16;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    TB_IDLE,
    TB_LOAD,
    TB_FULL
  } fir_tap_buffer_state_t;

  typedef struct packed {
    logic done;
    logic taps_valid;
  } fir_tap_buffer_flags_t;

  typedef struct packed {
    logic start;
  } fir_tap_buffer_ctrl_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fir_tap_buffer.sv
// Packs coefficients from the H stream into a parallel tap bank and signals
// the controller once a full set has been stored.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   TB_IDLE | bank empty or cleared, stream not accepted
//   TB_LOAD | accepting H words, counter selects the taps being written
//   TB_FULL | complete coefficient set held stable for the MAC datapath
module fir_tap_buffer
  import fir_tap_buffer_pkg::*;
#(
  parameter int NB_TAPS    = NB_TAPS_DEF,
  parameter int TAP_WIDTH  = TAP_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [DATA_WIDTH-1:0]        h_data_i,
  input  logic                         h_valid_i,
  output logic                         h_ready_o,
  output logic [NB_TAPS*TAP_WIDTH-1:0] taps_o,
  output logic                         taps_valid_o,
  output logic                         done_o
);

  localparam int TPW      = DATA_WIDTH / TAP_WIDTH;
  localparam int NB_WORDS = ceil_div(NB_TAPS, TPW);
  localparam int CNT_W    = $clog2(NB_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NB_WORDS - 1);

  fir_tap_buffer_state_t state;
  fir_tap_buffer_flags_t flags;
  fir_tap_buffer_ctrl_t  ctrl;
  logic [CNT_W-1:0]      cnt;
  logic                  done_q;
  logic                  hs;
  logic [TAP_WIDTH-1:0]  taps_q [NB_TAPS];

  assign ctrl = '{start: start_i};

  // Ready is decoded from the registered state only, never from h_valid_i.
  assign h_ready_o = (state == TB_LOAD);
  assign hs        = h_valid_i & h_ready_o;

  assign flags        = '{done: done_q, taps_valid: (state == TB_FULL)};
  assign done_o       = flags.done;
  assign taps_valid_o = flags.taps_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state  <= TB_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        TB_IDLE: begin
          if (ctrl.start) begin
            state <= TB_LOAD;
            cnt   <= '0;
          end
        end
        TB_LOAD: begin
          if (hs) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_WORD) begin
              state  <= TB_FULL;
              done_q <= 1'b1;
            end
          end
        end
        TB_FULL: begin
          if (ctrl.start) begin
            state <= TB_LOAD;
            cnt   <= '0;
          end
        end
        default: state <= TB_IDLE;
      endcase
    end
  end

  // Tap i lives in word i/TPW, sub-word i%TPW; tail sub-words past NB_TAPS
  // simply have no register to land in.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < NB_TAPS; i++) taps_q[i] <= '0;
    end else if (hs) begin
      for (int i = 0; i < NB_TAPS; i++) begin
        if (cnt == CNT_W'(i / TPW))
          taps_q[i] <= h_data_i[(i % TPW)*TAP_WIDTH +: TAP_WIDTH];
      end
    end
  end

  for (genvar g = 0; g < NB_TAPS; g++) begin : g_taps
    assign taps_o[g*TAP_WIDTH +: TAP_WIDTH] = taps_q[g];
  end

endmodule
